// File: rtl/regs_pkg.sv
// Shared widths and request bundle for the GPR write-back path.
// The optional bypass outputs are enabled by REGS_WB_BYPASS_EN.
package regs_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int NGPR   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NGPR-1:0] gpr_decode(
        input logic [ADDR_W-1:0] a,
        input logic              en
    );
        logic [NGPR-1:0] m;
        m = '0;
        if (en) m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regs_wb_pick.sv
// Combinational two-grant round-robin picker.
// Grant B must target a different GPR than grant A.
module regs_wb_pick #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int PW     = 2
) (
    input  logic [NREQ-1:0]        valid,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [PW-1:0]          rr_ptr,
    output logic [PW-1:0]          a_idx,
    output logic                   a_vld,
    output logic [PW-1:0]          b_idx,
    output logic                   b_vld
);

    int                j;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] cur;

    always_comb begin
        a_vld  = 1'b0;
        b_vld  = 1'b0;
        a_idx  = '0;
        b_idx  = '0;
        a_addr = '0;
        cur    = '0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            cur = addr[j*ADDR_W +: ADDR_W];
            if (valid[j]) begin
                if (!a_vld) begin
                    a_vld  = 1'b1;
                    a_idx  = PW'(j);
                    a_addr = cur;
                end else if (!b_vld && cur != a_addr) begin
                    b_vld = 1'b1;
                    b_idx = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter feeding the two GPR write ports, one cycle registered.
// Define REGS_WB_BYPASS_EN to add read-around forwarding outputs.
module regs_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = regs_pkg::ADDR_W,
    parameter int DATA_W = regs_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wbHold,
    input  logic [NREQ-1:0]        reqValid,
    input  logic [NREQ*ADDR_W-1:0] reqAddr,
    input  logic [NREQ*DATA_W-1:0] reqData,
    output logic [NREQ-1:0]        reqReady,
    output logic                   writeEn0,
    output logic [ADDR_W-1:0]      writeAddr0,
    output logic [DATA_W-1:0]      writeData0,
    output logic                   writeEn1,
    output logic [ADDR_W-1:0]      writeAddr1,
    output logic [DATA_W-1:0]      writeData1,
    output logic [31:0]            busyMask
`ifdef REGS_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]      fwdAddr0,
    input  logic [ADDR_W-1:0]      fwdAddr1,
    output logic                   fwdHit0,
    output logic                   fwdHit1,
    output logic [DATA_W-1:0]      fwdData0,
    output logic [DATA_W-1:0]      fwdData1
`endif
);

    import regs_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_req_t       req [NREQ];
    logic [PW-1:0] a_idx, b_idx;
    logic          a_vld, b_vld;
    logic          grant_a, grant_b;

    logic [PW-1:0] rr_q, rr_d;
    logic          en0_q, en0_d;
    logic          en1_q, en1_d;
    wb_req_t       p0_q, p0_d;
    wb_req_t       p1_q, p1_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i].addr = reqAddr[i*ADDR_W +: ADDR_W];
            req[i].data = reqData[i*DATA_W +: DATA_W];
        end
    end

    regs_wb_pick #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .PW     (PW)
    ) u_pick (
        .valid  (reqValid),
        .addr   (reqAddr),
        .rr_ptr (rr_q),
        .a_idx  (a_idx),
        .a_vld  (a_vld),
        .b_idx  (b_idx),
        .b_vld  (b_vld)
    );

    assign grant_a = a_vld & ~wbHold;
    assign grant_b = b_vld & ~wbHold;

    // Ready is forced low while reset is asserted, not just after it
    always_comb begin
        reqReady = '0;
        if (rst_n) begin
            if (grant_a) reqReady[a_idx] = 1'b1;
            if (grant_b) reqReady[b_idx] = 1'b1;
        end
    end

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
        return (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
    endfunction

    always_comb begin
        en0_d = grant_a;
        en1_d = grant_b;
        p0_d  = p0_q;
        p1_d  = p1_q;
        rr_d  = rr_q;
        if (grant_a) p0_d = req[a_idx];
        if (grant_b) p1_d = req[b_idx];
        if (grant_b)      rr_d = rr_next(b_idx);
        else if (grant_a) rr_d = rr_next(a_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= '0;
            en0_q <= 1'b0;
            en1_q <= 1'b0;
            p0_q  <= '0;
            p1_q  <= '0;
        end else begin
            rr_q  <= rr_d;
            en0_q <= en0_d;
            en1_q <= en1_d;
            p0_q  <= p0_d;
            p1_q  <= p1_d;
        end
    end

    assign writeEn0   = en0_q;
    assign writeAddr0 = p0_q.addr;
    assign writeData0 = p0_q.data;
    assign writeEn1   = en1_q;
    assign writeAddr1 = p1_q.addr;
    assign writeData1 = p1_q.data;

    assign busyMask = gpr_decode(p0_q.addr, en0_q)
                    | gpr_decode(p1_q.addr, en1_q);

`ifdef REGS_WB_BYPASS_EN
    logic h00, h01, h10, h11;

    assign h00 = en0_q && (p0_q.addr == fwdAddr0);
    assign h01 = en1_q && (p1_q.addr == fwdAddr0);
    assign h10 = en0_q && (p0_q.addr == fwdAddr1);
    assign h11 = en1_q && (p1_q.addr == fwdAddr1);

    assign fwdHit0  = h00 | h01;
    assign fwdHit1  = h10 | h11;
    assign fwdData0 = h01 ? p1_q.data : p0_q.data;
    assign fwdData1 = h11 ? p1_q.data : p0_q.data;
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter (default NREQ=3).
// Bypass checks are compiled in with REGS_WB_BYPASS_EN.
module tb_regs_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 64;

    logic              clk;
    logic              rst_n;
    logic              wb_hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DW-1:0]     wd0, wd1;
    logic [31:0]       busy;
`ifdef REGS_WB_BYPASS_EN
    logic [AW-1:0]     fa0, fa1;
    logic              fh0, fh1;
    logic [DW-1:0]     fd0, fd1;
`endif

    int n_checks;
    int n_fail;

    regs_wb_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbHold     (wb_hold),
        .reqValid   (req_valid),
        .reqAddr    (req_addr),
        .reqData    (req_data),
        .reqReady   (req_ready),
        .writeEn0   (we0),
        .writeAddr0 (wa0),
        .writeData0 (wd0),
        .writeEn1   (we1),
        .writeAddr1 (wa1),
        .writeData1 (wd1),
        .busyMask   (busy)
`ifdef REGS_WB_BYPASS_EN
        ,
        .fwdAddr0   (fa0),
        .fwdAddr1   (fa1),
        .fwdHit0    (fh0),
        .fwdHit1    (fh1),
        .fwdData0   (fd0),
        .fwdData1   (fd1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        wb_hold   = 1'b0;
        req_valid = '1;
        req_addr  = '0;
        req_data  = '0;
`ifdef REGS_WB_BYPASS_EN
        fa0 = '0;
        fa1 = '0;
`endif
        #3;
        check("rst_we0", we0, 0);
        check("rst_we1", we1, 0);
        check("rst_wa0", wa0, 0);
        check("rst_wd1", wd1, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        step();
        step();
        rst_n     = 1'b1;
        req_valid = '0;

        // basic two-write grant from rrPtr=0
        set_req(0, 5'd3, 64'h11);
        set_req(1, 5'd7, 64'h22);
        req_valid = 3'b011;
        #1 check("basic_ready", req_ready, 3'b011);
        step();
        check("basic_we0", we0, 1);
        check("basic_wa0", wa0, 3);
        check("basic_wd0", wd0, 64'h11);
        check("basic_we1", we1, 1);
        check("basic_wa1", wa1, 7);
        check("basic_wd1", wd1, 64'h22);
        check("basic_busy", busy, 32'h88);

        // fairness with rrPtr=2, distinct addresses
        set_req(0, 5'd1, 64'hA0);
        set_req(1, 5'd2, 64'hA1);
        set_req(2, 5'd4, 64'hA2);
        req_valid = 3'b111;
        #1 check("fair1_ready", req_ready, 3'b101);
        step();
        check("fair1_wa0", wa0, 4);
        check("fair1_wd0", wd0, 64'hA2);
        check("fair1_wa1", wa1, 1);
        check("fair1_wd1", wd1, 64'hA0);
        check("fair1_busy", busy, 32'h12);
        #1 check("fair2_ready", req_ready, 3'b110);
        step();
        check("fair2_wa0", wa0, 2);
        check("fair2_wa1", wa1, 4);
        check("fair2_busy", busy, 32'h14);
        #1 check("fair3_ready", req_ready, 3'b011);
        step();
        check("fair3_wa0", wa0, 1);
        check("fair3_wa1", wa1, 2);
        check("fair3_busy", busy, 32'h06);

        // hold: no grants, rrPtr stays at 2
        wb_hold = 1'b1;
        #1 check("hold_ready", req_ready, 0);
        step();
        check("hold_we0", we0, 0);
        check("hold_we1", we1, 0);
        check("hold_wa0", wa0, 1);
        check("hold_busy", busy, 0);
        wb_hold = 1'b0;
        #1 check("rel_ready", req_ready, 3'b101);
        step();
        check("rel_we0", we0, 1);
        check("rel_wa0", wa0, 4);

        // reset in the middle of traffic
        rst_n = 1'b0;
        #1;
        check("mrst_we0", we0, 0);
        check("mrst_we1", we1, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", req_ready, 0);
        step();
        rst_n = 1'b1;

        // all three target r5: serialised, port 1 idle
        set_req(0, 5'd5, 64'h51);
        set_req(1, 5'd5, 64'h52);
        set_req(2, 5'd5, 64'h53);
        req_valid = 3'b111;
        #1 check("conf1_ready", req_ready, 3'b001);
        step();
        check("conf1_we0", we0, 1);
        check("conf1_wd0", wd0, 64'h51);
        check("conf1_we1", we1, 0);
        check("conf1_busy", busy, 32'h20);
        req_valid = 3'b110;
        #1 check("conf2_ready", req_ready, 3'b010);
        step();
        check("conf2_wd0", wd0, 64'h52);
        check("conf2_we1", we1, 0);
        req_valid = 3'b100;
        #1 check("conf3_ready", req_ready, 3'b100);
        step();
        check("conf3_wd0", wd0, 64'h53);
        check("conf3_we1", we1, 0);

        // partial conflict: req1 skipped, req2 takes port 1
        set_req(0, 5'd3, 64'h31);
        set_req(1, 5'd3, 64'h32);
        set_req(2, 5'd6, 64'h33);
        req_valid = 3'b111;
        #1 check("part_ready", req_ready, 3'b101);
        step();
        check("part_wa0", wa0, 3);
        check("part_wd0", wd0, 64'h31);
        check("part_wa1", wa1, 6);
        check("part_wd1", wd1, 64'h33);
        check("part_busy", busy, 32'h48);

        // idle: enables drop, addr/data held
        req_valid = '0;
        #1 check("idle_ready", req_ready, 0);
        step();
        check("idle_we0", we0, 0);
        check("idle_we1", we1, 0);
        check("idle_wa0", wa0, 3);
        check("idle_wd1", wd1, 64'h33);
        check("idle_busy", busy, 0);

`ifdef REGS_WB_BYPASS_EN
        set_req(0, 5'd9, 64'hDEAD);
        req_valid = 3'b001;
        #1 check("byp_ready", req_ready, 3'b001);
        step();
        req_valid = '0;
        fa0 = 5'd9;
        fa1 = 5'd10;
        #1;
        check("byp_hit0", fh0, 1);
        check("byp_data0", fd0, 64'hDEAD);
        check("byp_hit1", fh1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
